draw_painter: RTL and testbench

- Parametrised successor of the fixed-size pixel-sweep/text painter for the VGA exercise designs.
- Pixel engine: sweeps a 2^XW x 2^YW framebuffer one pixel per cycle through a seven-pattern colour sequence, each pattern held 2^HOLD_W cycles, with optional looping.
- Text engine (concurrent, independent): on a key press, erases the previous MSG_LEN-character message and writes a programmable message at a new character-cell position.

---
 rtl/draw_pkg.sv | 29 ++
 rtl/draw_text_writer.sv | 89 ++++++++
 rtl/draw_painter.sv | 132 +++++++++++++
 tb/tb_draw_painter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the pixel-sweep / text painter.
package draw_pkg;

    typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5, P6, IDLE} pattern_t;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // {R,G,B} selector: 1 = channel at full scale, 0 = channel at zero
    localparam logic [2:0] SEL_WHITE   = 3'b111;
    localparam logic [2:0] SEL_CYAN    = 3'b011;
    localparam logic [2:0] SEL_RED     = 3'b100;
    localparam logic [2:0] SEL_MAGENTA = 3'b101;
    localparam logic [2:0] SEL_GREEN   = 3'b010;
    localparam logic [2:0] SEL_YELLOW  = 3'b110;
    localparam logic [2:0] SEL_NONE    = 3'b000;

    function automatic logic [2:0] pattern_sel(input pattern_t p);
        case (p)
            P0:      return SEL_WHITE;
            P1:      return SEL_CYAN;
            P2:      return SEL_RED;
            P3:      return SEL_MAGENTA;
            P4:      return SEL_GREEN;
            P5:      return SEL_YELLOW;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/draw_text_writer.sv
// Text engine: on a key press, erases the previous message and writes a new one
// at the latched character-cell position.
module draw_text_writer import draw_pkg::*; #(
    parameter int unsigned CXW     = 5,
    parameter int unsigned CYW     = 4,
    parameter int unsigned MSG_LEN = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   TXT_KEY,
    input  logic [CXW+CYW-1:0]     TXT_POS,
    input  logic [8*MSG_LEN-1:0]   MSG,
    output logic [CXW-1:0]         CX,
    output logic [CYW-1:0]         CY,
    output logic [7:0]             CHAR,
    output logic                   CHAR_WE,
    output logic                   TXT_BUSY
);

    localparam int unsigned PW    = CXW + CYW;
    localparam int unsigned CNT_W = $clog2(2 * MSG_LEN);
    localparam int unsigned LAST  = 2 * MSG_LEN - 1;

    logic                 r_key_prev;
    logic [PW-1:0]        r_pos;
    logic [8*MSG_LEN-1:0] r_msg;
    logic [CNT_W-1:0]     r_cnt;
    logic [CXW-1:0]       r_cx;
    logic [CYW-1:0]       r_cy;
    logic [7:0]           r_char;
    logic                 r_char_we;
    logic                 r_busy;
    logic                 w_fall;

    assign w_fall = r_key_prev & ~TXT_KEY;

    // r_cnt indexes the cell currently presented; r_pos holds old position until the press, new after
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_key_prev <= 1'b1;
            r_pos      <= '0;
            r_msg      <= '0;
            r_cnt      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_char     <= '0;
            r_char_we  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_key_prev <= TXT_KEY;
            if (!r_busy) begin
                if (w_fall) begin
                    r_pos     <= TXT_POS;
                    r_msg     <= MSG;
                    r_cnt     <= '0;
                    r_busy    <= 1'b1;
                    r_char_we <= 1'b1;
                    r_cx      <= r_pos[PW-1:CYW];
                    r_cy      <= r_pos[CYW-1:0];
                    r_char    <= SPACE_CHAR;
                end
            end else if (r_cnt == CNT_W'(LAST)) begin
                r_busy    <= 1'b0;
                r_char_we <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(MSG_LEN - 1)) begin
                    r_cx   <= r_pos[PW-1:CYW];
                    r_cy   <= r_pos[CYW-1:0];
                    r_char <= r_msg[7:0];
                    r_msg  <= r_msg >> 8;
                end else begin
                    r_cx <= r_cx + CXW'(1);
                    if (r_cnt >= CNT_W'(MSG_LEN)) begin
                        r_char <= r_msg[7:0];
                        r_msg  <= r_msg >> 8;
                    end
                end
            end
        end
    end

    assign CX       = r_cx;
    assign CY       = r_cy;
    assign CHAR     = r_char;
    assign CHAR_WE  = r_char_we;
    assign TXT_BUSY = r_busy;

endmodule

// File: rtl/draw_painter.sv
// Pixel sweep through seven colour patterns plus an independent text engine.
module draw_painter import draw_pkg::*; #(
    parameter int unsigned XW      = 8,
    parameter int unsigned YW      = 8,
    parameter int unsigned CW      = 3,
    parameter int unsigned HOLD_W  = 24,
    parameter int unsigned CXW     = 5,
    parameter int unsigned CYW     = 4,
    parameter int unsigned MSG_LEN = 8,
    parameter int unsigned LOOP    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TXT_KEY,
    input  logic [CXW+CYW-1:0]   TXT_POS,
    input  logic [8*MSG_LEN-1:0] MSG,
    output logic [XW-1:0]        X,
    output logic [YW-1:0]        Y,
    output logic [CW-1:0]        R,
    output logic [CW-1:0]        G,
    output logic [CW-1:0]        B,
    output logic                 PIX_WE,
    output logic                 DONE,
    output logic [CXW-1:0]       CX,
    output logic [CYW-1:0]       CY,
    output logic [7:0]           CHAR,
    output logic                 CHAR_WE,
    output logic                 TXT_BUSY
);

    localparam int unsigned AW = XW + YW;

    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [CW-1:0]     r_r, r_g, r_b;
    logic              r_pix_we;
    logic              r_done;
    pattern_t          r_pat;
    logic [HOLD_W-1:0] r_hold;

    logic [AW-1:0]     w_addr_nxt;
    logic [XW-1:0]     w_x_nxt;
    logic [YW-1:0]     w_y_nxt;
    logic [CW-1:0]     w_grad_g, w_grad_b;
    logic [2:0]        w_sel;

    assign w_addr_nxt = {r_y, r_x} + AW'(1);
    assign w_x_nxt    = w_addr_nxt[XW-1:0];
    assign w_y_nxt    = w_addr_nxt[AW-1:XW];
    assign w_sel      = pattern_sel(r_pat);

    // Gradient takes the top CW bits of the new address; narrow coordinates pad at the LSBs
    if (YW >= CW) begin : g_grad_y
        assign w_grad_g = w_y_nxt[YW-1 -: CW];
    end else begin : g_grad_y_ext
        assign w_grad_g = {w_y_nxt, {(CW - YW){1'b0}}};
    end

    if (XW >= CW) begin : g_grad_x
        assign w_grad_b = w_x_nxt[XW-1 -: CW];
    end else begin : g_grad_x_ext
        assign w_grad_b = {w_x_nxt, {(CW - XW){1'b0}}};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_x      <= '0;
            r_y      <= '0;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_pix_we <= 1'b0;
            r_done   <= 1'b0;
            r_pat    <= P0;
            r_hold   <= '0;
        end else if (r_pat == IDLE) begin
            r_x      <= '0;
            r_y      <= '0;
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_pix_we <= 1'b0;
            r_done   <= 1'b1;
        end else begin
            {r_y, r_x} <= w_addr_nxt;
            r_pix_we   <= 1'b1;
            if (r_pat == P6) begin
                r_r <= '0;
                r_g <= w_grad_g;
                r_b <= w_grad_b;
            end else begin
                r_r <= {CW{w_sel[2]}};
                r_g <= {CW{w_sel[1]}};
                r_b <= {CW{w_sel[0]}};
            end
            r_hold <= r_hold + HOLD_W'(1);
            if (r_hold == '1) begin
                if (r_pat == P6) begin
                    r_pat <= (LOOP != 0) ? P0 : IDLE;
                end else begin
                    r_pat <= pattern_t'(r_pat + 3'd1);
                end
            end
        end
    end

    assign X      = r_x;
    assign Y      = r_y;
    assign R      = r_r;
    assign G      = r_g;
    assign B      = r_b;
    assign PIX_WE = r_pix_we;
    assign DONE   = r_done;

    draw_text_writer #(
        .CXW     (CXW),
        .CYW     (CYW),
        .MSG_LEN (MSG_LEN)
    ) u_text (
        .CLK      (CLK),
        .RST      (RST),
        .TXT_KEY  (TXT_KEY),
        .TXT_POS  (TXT_POS),
        .MSG      (MSG),
        .CX       (CX),
        .CY       (CY),
        .CHAR     (CHAR),
        .CHAR_WE  (CHAR_WE),
        .TXT_BUSY (TXT_BUSY)
    );

endmodule

// File: tb/tb_draw_painter.sv
// Directed bench: LOOP=0 and LOOP=1 painters with a small framebuffer and short hold.
module tb_draw_painter;

    logic        clk;
    logic        rst;
    logic        key0, key1;
    logic [8:0]  pos;
    logic [63:0] msg;

    logic [1:0] x0, y0, r0, g0, b0, x1, y1, r1, g1, b1;
    logic       we0, done0, we1, done1;
    logic [4:0] cx0, cx1;
    logic [3:0] cy0, cy1;
    logic [7:0] ch0, ch1;
    logic       cwe0, cwe1, busy0, busy1;

    int total = 0;
    int bad   = 0;

    logic [7:0] msg_b [8] = '{8'h4D, 8'h61, 8'h6B, 8'h6F, 8'h74, 8'h6F, 8'h2E, 8'h49};
    logic [2:0] pat_sel [6] = '{3'b111, 3'b011, 3'b100, 3'b101, 3'b010, 3'b110};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    draw_painter #(.XW(2), .YW(2), .CW(2), .HOLD_W(4), .CXW(5), .CYW(4), .MSG_LEN(8), .LOOP(0)) u_dut0 (
        .CLK(clk), .RST(rst), .TXT_KEY(key0), .TXT_POS(pos), .MSG(msg),
        .X(x0), .Y(y0), .R(r0), .G(g0), .B(b0), .PIX_WE(we0), .DONE(done0),
        .CX(cx0), .CY(cy0), .CHAR(ch0), .CHAR_WE(cwe0), .TXT_BUSY(busy0)
    );

    draw_painter #(.XW(2), .YW(2), .CW(2), .HOLD_W(4), .CXW(5), .CYW(4), .MSG_LEN(8), .LOOP(1)) u_dut1 (
        .CLK(clk), .RST(rst), .TXT_KEY(key1), .TXT_POS(pos), .MSG(msg),
        .X(x1), .Y(y1), .R(r1), .G(g1), .B(b1), .PIX_WE(we1), .DONE(done1),
        .CX(cx1), .CY(cy1), .CHAR(ch1), .CHAR_WE(cwe1), .TXT_BUSY(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int col, input int row);
        pos  = {5'(col), 4'(row)};
        key0 = 1'b0;
        tick();
        key0 = 1'b1;
    endtask

    task automatic check_cell(input int j, input int oc, input int orw, input int nc, input int nr);
        int ecx, ecy;
        logic [7:0] ech;
        if (j < 8) begin
            ecx = (oc + j) % 32;
            ecy = orw;
            ech = 8'h20;
        end else begin
            ecx = (nc + j - 8) % 32;
            ecy = nr;
            ech = msg_b[j-8];
        end
        chk($sformatf("cell%0d_we", j),   32'(cwe0),  32'd1);
        chk($sformatf("cell%0d_busy", j), 32'(busy0), 32'd1);
        chk($sformatf("cell%0d_cx", j),   32'(cx0),   32'(ecx));
        chk($sformatf("cell%0d_cy", j),   32'(cy0),   32'(ecy));
        chk($sformatf("cell%0d_char", j), 32'(ch0),   32'(ech));
    endtask

    task automatic run_full(input int oc, input int orw, input int nc, input int nr);
        int busy_cnt;
        busy_cnt = 0;
        press(nc, nr);
        for (int j = 0; j < 16; j++) begin
            check_cell(j, oc, orw, nc, nr);
            busy_cnt += int'(busy0);
            tick();
        end
        chk("busy_len", 32'(busy_cnt), 32'd16);
        chk("end_busy", 32'(busy0), 32'd0);
        chk("end_we",   32'(cwe0),  32'd0);
        chk("end_cx",   32'(cx0),   32'((nc + 7) % 32));
        chk("end_cy",   32'(cy0),   32'(nr));
        chk("end_char", 32'(ch0),   32'h49);
    endtask

    initial begin
        logic [5:0] exp_rgb;
        logic [3:0] exp_a;
        logic [2:0] sel;
        int p;

        rst  = 1'b1;
        key0 = 1'b1;
        key1 = 1'b1;
        pos  = '0;
        for (int i = 0; i < 8; i++) msg[8*i +: 8] = msg_b[i];
        #12;

        chk("rst_addr",  32'({y0, x0}),     32'd0);
        chk("rst_rgb",   32'({r0, g0, b0}), 32'd0);
        chk("rst_we",    32'(we0),          32'd0);
        chk("rst_done",  32'(done0),        32'd0);
        chk("rst_cx",    32'(cx0),          32'd0);
        chk("rst_cy",    32'(cy0),          32'd0);
        chk("rst_char",  32'(ch0),          32'd0);
        chk("rst_cwe",   32'(cwe0),         32'd0);
        chk("rst_busy",  32'(busy0),        32'd0);
        rst = 1'b0;

        // Seven patterns of 16 cycles each, address starting at 1
        for (int k = 1; k <= 112; k++) begin
            tick();
            exp_a = 4'(k % 16);
            p = (k - 1) / 16;
            if (p < 6) begin
                sel = pat_sel[p];
                exp_rgb = {{2{sel[2]}}, {2{sel[1]}}, {2{sel[0]}}};
            end else begin
                exp_rgb = {2'b00, exp_a[3:2], exp_a[1:0]};
            end
            chk("sweep_addr0", 32'({y0, x0}),     32'(exp_a));
            chk("sweep_rgb0",  32'({r0, g0, b0}), 32'(exp_rgb));
            chk("sweep_we0",   32'(we0),          32'd1);
            chk("sweep_done0", 32'(done0),        32'd0);
            chk("sweep_addr1", 32'({y1, x1}),     32'(exp_a));
            chk("sweep_rgb1",  32'({r1, g1, b1}), 32'(exp_rgb));
            if (k == 105) begin
                chk("grad_y", 32'(y0), 32'd2);
                chk("grad_x", 32'(x0), 32'd1);
                chk("grad_r", 32'(r0), 32'd0);
                chk("grad_g", 32'(g0), 32'd2);
                chk("grad_b", 32'(b0), 32'd1);
            end
        end

        // LOOP=0 parks in idle; LOOP=1 wraps to white with a continuous address
        for (int k = 113; k <= 162; k++) begin
            tick();
            chk("idle_done0", 32'(done0),        32'd1);
            chk("idle_we0",   32'(we0),          32'd0);
            chk("idle_addr0", 32'({y0, x0}),     32'd0);
            chk("idle_rgb0",  32'({r0, g0, b0}), 32'd0);
            chk("loop_addr1", 32'({y1, x1}),     32'(k % 16));
            chk("loop_done1", 32'(done1),        32'd0);
            if (k <= 128) chk("loop_rgb1", 32'({r1, g1, b1}), 32'h3F);
        end

        chk("pre_busy", 32'(busy0), 32'd0);
        run_full(0, 0, 5, 3);
        tick();
        chk("hold_cx",   32'(cx0),  32'd12);
        chk("hold_char", 32'(ch0),  32'h49);
        chk("hold_we",   32'(cwe0), 32'd0);

        run_full(5, 3, 30, 1);
        tick();

        // Third press: a second edge mid-write is ignored, then reset aborts
        press(7, 6);
        for (int j = 0; j <= 13; j++) begin
            check_cell(j, 30, 1, 7, 6);
            if (j == 11) key0 = 1'b0;
            if (j < 13) tick();
        end
        rst = 1'b1;
        #1;
        chk("abort_cwe",   32'(cwe0),         32'd0);
        chk("abort_busy",  32'(busy0),        32'd0);
        chk("abort_addr0", 32'({y0, x0}),     32'd0);
        chk("abort_addr1", 32'({y1, x1}),     32'd0);
        chk("abort_rgb1",  32'({r1, g1, b1}), 32'd0);
        key0 = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        chk("restart_addr1", 32'({y1, x1}),     32'd1);
        chk("restart_rgb1",  32'({r1, g1, b1}), 32'h3F);
        chk("restart_busy",  32'(busy0),        32'd0);

        run_full(0, 0, 4, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
